regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback requesters, e.g. ALU result, load return and CSR/mul unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered output stage drives the regfile write port (we/waddr/wdata) with one cycle of latency.
- Exports the in-flight write (pend_*) so decode can forward or bypass it.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, register data width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  1 = grant nothing this cycle
req_valid  in  NUM_REQ  requester i has a write pending
req_ready  out  NUM_REQ  one-hot grant; a transfer happens when valid[i] and ready[i] are both 1
req_addr  in  NUM_REQ*ADDR_W  requester i destination, slice [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  requester i data, slice [i*DATA_W +: DATA_W]
wb_we  out  1  regfile write enable
wb_waddr  out  ADDR_W  regfile write address
wb_wdata  out  DATA_W  regfile write data
pend_valid  out  1  output stage holds a write to a nonzero register (equals wb_we)
pend_addr  out  ADDR_W  equals wb_waddr
grant_idx  out  clog2(NUM_REQ)  index of the last accepted requester, for debug/perf

Behaviour:
- Reset (async assert, release synchronised by the environment):
  - wb_we=0, wb_waddr=0, wb_wdata=0, grant_idx=0, round-robin pointer ptr=0.
  - req_ready=0 while rst=1.
- Arbitration (combinational, same cycle):
  - If stall=0, scan indices ptr, ptr+1, …, wrapping mod NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - req_ready never depends on anything except req_valid, ptr, stall and rst.
- Accept (rising edge with a grant g):
  - wb_waddr<=req_addr[g], wb_wdata<=req_data[g], grant_idx<=g.
  - wb_we<=(req_addr[g]!=0). A write to x0 is consumed (handshake completes) but never asserts we.
  - ptr<=(g+1) mod NUM_REQ.
- No grant (stall=1 or no valid): wb_we<=0. wb_waddr, wb_wdata, grant_idx and ptr hold.
- Latency: a request accepted on edge N appears on wb_* during cycle N..N+1. The regfile commits it at edge N+1.
- Throughput: one write per cycle. Output stage never back-pressures.
- Requesters must hold valid/addr/data stable until accepted. Deasserting valid before acceptance is legal; the request is simply not granted.
- Same destination from two requesters in one cycle: the one nearer ptr is written first, the other on a later cycle. No merging, no reordering beyond round-robin.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0. Worst-case wait is NUM_REQ-1 grants.
- Stall asserted for one cycle: no grant and ptr unchanged. Arbitration resumes from the same ptr.
- rst asserted mid-operation: the output stage clears immediately (async), so an in-flight write is dropped. Requesters must re-present the request after reset.

Decomposition:
- Shared defines header supplies ZeroWord, WriteEnable/WriteDisable, RegBus and RegAddrBus widths; parameter defaults derive from them.
- One sub-module, rr_arbiter: parameterised round-robin one-hot grant from request vector plus pointer, fully combinational, reusable for other shared ports.
- Output register and pointer state stay in regfile_wb_arbiter.

Test Plan:
- Reset: assert rst mid-run with wb_we=1 -> wb_we, wb_waddr, wb_wdata drop to 0 without waiting for a clock edge; after release, first grant goes to the lowest valid index ≥0.
- Single requester: req 1 valid, addr=5, data=0xDEADBEEF -> ready[1]=1 same cycle; next cycle wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF, pend_valid=1, pend_addr=5.
- Fairness: NUM_REQ=3, all valid for 6 cycles with distinct addrs 1/2/3 -> grant_idx sequence 0,1,2,0,1,2 and one wb_we pulse per cycle.
- x0 drop: req 0 valid, addr=0, data=0x1234 -> ready[0]=1, next cycle wb_we=0; ptr advances to 1.
- Stall: all valid, stall=1 for 2 cycles after a grant to 1 -> req_ready=0, wb_we=0 both cycles; on release the grant goes to 2.
- Same-address collision: req0 and req2 both write addr 7 with data 0xA and 0xB, ptr=2 -> 0xB written first, 0xA next cycle; final regfile x7=0xA.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Provides the register bus widths, the zero-word / write-enable
// constants used by the output stage, and a small pointer helper
// shared by the arbiter and its round-robin core.
package regfile_wb_arbiter_pkg;

    // Register data bus width (RegBus) and register address width (RegAddrBus).
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic                 WRITE_ENABLE  = 1'b1;
    localparam logic                 WRITE_DISABLE = 1'b0;

    typedef logic [REG_BUS_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index that follows idx when counting modulo n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector starting at ptr_i and wrapping modulo N;
// the first asserted request wins. Nothing is granted when en_i is low.
// Ports:
//   req_i        request vector
//   ptr_i        index that has highest priority this cycle (must be < N)
//   en_i         1 = grant allowed this cycle
//   gnt_o        one-hot grant (all zero when nothing granted)
//   gnt_idx_o    binary index of the winner (0 when nothing granted)
//   gnt_valid_o  1 = some requester was granted
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    // Priority scan from the pointer, wrapping once around the vector.
    always_comb begin
        int  idx;
        logic found;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && en_i && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PW'(idx);
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single regfile write port between NUM_REQ writeback
// requesters using round-robin arbitration with a valid/ready handshake.
// The winning write is registered and presented on wb_* one cycle later;
// the same registered write is exported on pend_* for decode bypassing.
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_i          asynchronous active-high reset
//   stall_i        1 = grant nothing this cycle
//   req_valid_i    per-requester write pending
//   req_ready_o    one-hot grant (transfer when valid & ready)
//   req_addr_i     packed destinations, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_i     packed data, requester i at [i*DATA_W +: DATA_W]
//   wb_we_o        regfile write enable
//   wb_waddr_o     regfile write address
//   wb_wdata_o     regfile write data
//   pend_valid_o   in-flight write targets a nonzero register (= wb_we_o)
//   pend_addr_o    in-flight write address (= wb_waddr_o)
//   grant_idx_o    index of the last accepted requester
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = REG_ADDR_BUS_W,
    localparam int GW = idx_width(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic                      wb_we_o,
    output logic [ADDR_W-1:0]         wb_waddr_o,
    output logic [DATA_W-1:0]         wb_wdata_o,
    output logic                      pend_valid_o,
    output logic [ADDR_W-1:0]         pend_addr_o,
    output logic [GW-1:0]             grant_idx_o
);

    logic                 arb_en_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [GW-1:0]        gnt_idx_s;
    logic                 gnt_valid_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_data_s;

    logic [GW-1:0]        ptr_q,       ptr_d;
    logic                 we_q,        we_d;
    logic [ADDR_W-1:0]    waddr_q,     waddr_d;
    logic [DATA_W-1:0]    wdata_q,     wdata_d;
    logic [GW-1:0]        grant_idx_q, grant_idx_d;

    // Arbitration is suppressed by stall and while reset is held, so ready
    // depends only on valid, pointer, stall and reset.
    always_comb begin
        arb_en_s = ~rst_i & ~stall_i;
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .en_i        (arb_en_s),
        .gnt_o       (gnt_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Mux the winning requester's address and data.
    always_comb begin
        sel_addr_s = req_addr_i[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
        sel_data_s = req_data_i[int'(gnt_idx_s)*DATA_W +: DATA_W];
    end

    // Next state of the output stage and round-robin pointer.
    always_comb begin
        ptr_d       = ptr_q;
        we_d        = WRITE_DISABLE;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        grant_idx_d = grant_idx_q;
        if (gnt_valid_s) begin
            // A write to x0 completes the handshake but never reaches the regfile.
            we_d        = (sel_addr_s != {ADDR_W{1'b0}}) ? WRITE_ENABLE : WRITE_DISABLE;
            waddr_d     = sel_addr_s;
            wdata_d     = sel_data_s;
            grant_idx_d = gnt_idx_s;
            ptr_d       = GW'(wrap_inc(int'(gnt_idx_s), NUM_REQ));
        end else begin
            we_d = WRITE_DISABLE;
        end
    end

    // Output stage and pointer registers; reset drops any in-flight write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            we_q        <= WRITE_DISABLE;
            waddr_q     <= '0;
            wdata_q     <= DATA_W'(ZERO_WORD);
            grant_idx_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign req_ready_o  = gnt_s;
    assign wb_we_o      = we_q;
    assign wb_waddr_o   = waddr_q;
    assign wb_wdata_o   = wdata_q;
    assign pend_valid_o = we_q;
    assign pend_addr_o  = waddr_q;
    assign grant_idx_o  = grant_idx_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (NUM_REQ=3).
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            wb_we;
    logic [AW-1:0]   wb_waddr;
    logic [DW-1:0]   wb_wdata;
    logic            pend_valid;
    logic [AW-1:0]   pend_addr;
    logic [GW-1:0]   grant_idx;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .wb_we_o(wb_we), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata),
        .pend_valid_o(pend_valid), .pend_addr_o(pend_addr),
        .grant_idx_o(grant_idx)
    );

    // Environment regfile: commits whatever the write port presents.
    logic [DW-1:0] rf [32];
    always @(posedge clk) begin
        if (wb_we) rf[wb_waddr] <= wb_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    int            exp_gidx;
    int            m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First valid requester at or after p (wrapping), or -1.
    function automatic int model_grant(input logic [N-1:0] v, input int p, input logic s);
        if (s) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic s,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        req_valid = v;
        stall     = s;
        req_addr  = a;
        req_data  = d;
    endtask

    // One clock: check ready against the model, clock, check registered outputs.
    task automatic cycle(input string name, output int g);
        logic [N-1:0] er;
        #1;
        g  = model_grant(req_valid, m_ptr, stall);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check({name, " ready"}, 64'(req_ready), 64'(er));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            exp_waddr = req_addr[g*AW +: AW];
            exp_wdata = req_data[g*DW +: DW];
            exp_we    = (exp_waddr != 0);
            exp_gidx  = g;
            m_ptr     = (g + 1) % N;
        end else begin
            exp_we = 1'b0;
        end
        check({name, " we"},         64'(wb_we),      64'(exp_we));
        check({name, " waddr"},      64'(wb_waddr),   64'(exp_waddr));
        check({name, " wdata"},      64'(wb_wdata),   64'(exp_wdata));
        check({name, " grant_idx"},  64'(grant_idx),  64'(exp_gidx));
        check({name, " pend_valid"}, 64'(pend_valid), 64'(exp_we));
        check({name, " pend_addr"},  64'(pend_addr),  64'(exp_waddr));
    endtask

    task automatic do_reset();
        drive('0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        check("reset we",    64'(wb_we),     64'd0);
        check("reset waddr", 64'(wb_waddr),  64'd0);
        check("reset wdata", 64'(wb_wdata),  64'd0);
        check("reset gidx",  64'(grant_idx), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_gidx  = 0;
        m_ptr     = 0;
    endtask

    typedef struct {
        logic [N-1:0]    valid;
        logic            stall;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic [N-1:0]    e_ready;
        logic            e_we;
        logic [AW-1:0]   e_waddr;
        logic [DW-1:0]   e_wdata;
        logic [GW-1:0]   e_gidx;
    } vec_t;

    vec_t vt [7];

    initial begin
        int g;
        logic [N*AW-1:0] a123;
        logic [N*DW-1:0] d123;
        logic [N-1:0]    pv;
        logic [N*AW-1:0] pa;
        logic [N*DW-1:0] pd;
        logic [N-1:0]    v;

        a123 = {5'd3, 5'd2, 5'd1};
        d123 = {32'h33, 32'h22, 32'h11};
        // Sequence from reset (ptr=0).
        vt[0] = '{3'b010, 1'b0, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                  3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1};
        vt[1] = '{3'b000, 1'b0, '0, '0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1};
        vt[2] = '{3'b001, 1'b0, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234},
                  3'b001, 1'b0, 5'd0, 32'h1234, 2'd0};
        vt[3] = '{3'b111, 1'b0, a123, d123, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1};
        vt[4] = '{3'b111, 1'b0, a123, d123, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2};
        vt[5] = '{3'b111, 1'b1, a123, d123, 3'b000, 1'b0, 5'd3, 32'h33, 2'd2};
        vt[6] = '{3'b111, 1'b0, a123, d123, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0};

        #2;
        do_reset();

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].valid, vt[i].stall, vt[i].addr, vt[i].data);
            #1;
            check($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vt[i].e_ready));
            cycle($sformatf("vec%0d", i), g);
            check($sformatf("vec%0d tbl we", i),    64'(wb_we),     64'(vt[i].e_we));
            check($sformatf("vec%0d tbl waddr", i), 64'(wb_waddr),  64'(vt[i].e_waddr));
            check($sformatf("vec%0d tbl wdata", i), 64'(wb_wdata),  64'(vt[i].e_wdata));
            check($sformatf("vec%0d tbl gidx", i),  64'(grant_idx), 64'(vt[i].e_gidx));
        end

        // Fairness: all valid for 6 cycles -> 0,1,2,0,1,2.
        do_reset();
        drive(3'b111, 1'b0, a123, d123);
        for (int k = 0; k < 6; k++) begin
            cycle("fair", g);
            check("fair gidx", 64'(grant_idx), 64'(k % 3));
            check("fair we",   64'(wb_we),     64'd1);
        end

        // Stall two cycles after a grant to 1; resume at 2.
        do_reset();
        drive(3'b111, 1'b0, a123, d123);
        cycle("stall pre0", g);
        cycle("stall pre1", g);
        check("stall pre gidx", 64'(grant_idx), 64'd1);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("stall ready", 64'(req_ready), 64'd0);
            cycle("stall", g);
            check("stall we", 64'(wb_we), 64'd0);
        end
        stall = 1'b0;
        #1;
        check("stall release ready", 64'(req_ready), 64'b100);
        cycle("stall release", g);

        // Same-address collision with ptr=2.
        do_reset();
        drive(3'b010, 1'b0, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h5, 32'h0});
        cycle("coll setup", g);
        drive(3'b101, 1'b0, {5'd7, 5'd0, 5'd7}, {32'hB, 32'h0, 32'hA});
        cycle("coll first", g);
        check("coll first wdata", 64'(wb_wdata), 64'hB);
        check("coll first waddr", 64'(wb_waddr), 64'd7);
        req_valid = 3'b001;
        cycle("coll second", g);
        check("coll second wdata", 64'(wb_wdata), 64'hA);
        drive('0, 1'b0, '0, '0);
        cycle("coll idle", g);
        check("coll rf x7", 64'(rf[7]), 64'hA);

        // Asynchronous reset with a write in flight.
        drive(3'b001, 1'b0, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'hCAFE});
        cycle("areset pre", g);
        check("areset pre we", 64'(wb_we), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("areset we",    64'(wb_we),     64'd0);
        check("areset waddr", 64'(wb_waddr),  64'd0);
        check("areset wdata", 64'(wb_wdata),  64'd0);
        check("areset ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_gidx = 0; m_ptr = 0;
        drive(3'b110, 1'b0, a123, d123);
        #1;
        check("areset first ready", 64'(req_ready), 64'b010);
        cycle("areset first", g);

        // Randomized traffic against the model.
        do_reset();
        pv = '0; pa = '0; pd = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i*AW +: AW] = AW'($urandom_range(0, 31));
                    pd[i*DW +: DW] = $urandom;
                end else if (pv[i] && $urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            v = pv;
            drive(v, ($urandom_range(0, 4) == 0), pa, pd);
            cycle("rand", g);
            if (g >= 0) pv[g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
